// File: rtl/emu_uart_fifo_ctrl_if.sv
// Register bus plus UART byte streams for emu_uart_fifo_ctrl.
// The master side drives requests and RX bytes; the slave returns reads, TX bytes and irq.
interface emu_uart_fifo_ctrl_if;
    logic        reg_wen;
    logic        reg_ren;
    logic [3:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        reg_rvalid;
    logic        tx_valid;
    logic [7:0]  tx_ch;
    logic        rx_valid;
    logic [7:0]  rx_ch;
    logic        irq;

    modport master (
        output reg_wen, reg_ren, reg_addr, reg_wdata, rx_valid, rx_ch,
        input  reg_rdata, reg_rvalid, tx_valid, tx_ch, irq
    );

    modport slave (
        input  reg_wen, reg_ren, reg_addr, reg_wdata, rx_valid, rx_ch,
        output reg_rdata, reg_rvalid, tx_valid, tx_ch, irq
    );
endinterface

// File: rtl/emu_uart_fifo_ctrl.sv
// Emulated UART front end: register-mapped TX/RX byte FIFOs, a paced TX emitter
// (IDLE/SEND/GAP) and a level irq while RX data is waiting.
module emu_uart_fifo_ctrl #(
    parameter int FIFO_DEPTH = 16,
    parameter int TX_GAP     = 4
) (
    input logic                 clk,
    input logic                 resetn,
    emu_uart_fifo_ctrl_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(TX_GAP + 2);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [3:0] A_TXDATA = 4'h0;
    localparam logic [3:0] A_RXDATA = 4'h4;
    localparam logic [3:0] A_STATUS = 4'h8;

    logic [7:0]    tx_mem_q [FIFO_DEPTH];
    logic [7:0]    tx_mem_d [FIFO_DEPTH];
    logic [7:0]    rx_mem_q [FIFO_DEPTH];
    logic [7:0]    rx_mem_d [FIFO_DEPTH];
    logic [AW:0]   tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [AW:0]   rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] gap_cnt_q, gap_cnt_d;
    logic [7:0]    tx_ch_q, tx_ch_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;
    logic          tx_drop_q, tx_drop_d;
    logic          rx_ovr_q, rx_ovr_d;

    logic [AW:0]   tx_cnt, rx_cnt;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic          wr_tx, rd_rx, tx_push, tx_pop, rx_push, rx_pop;
    logic          set_drop, set_ovr, clr_drop, clr_ovr;
    logic [31:0]   status;
    logic          unused_wdata;

    assign tx_cnt   = tx_wptr_q - tx_rptr_q;
    assign rx_cnt   = rx_wptr_q - rx_rptr_q;
    assign tx_empty = (tx_wptr_q == tx_rptr_q);
    assign rx_empty = (rx_wptr_q == rx_rptr_q);
    assign tx_full  = (tx_wptr_q[AW] != tx_rptr_q[AW]) && (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]);
    assign rx_full  = (rx_wptr_q[AW] != rx_rptr_q[AW]) && (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]);

    // A full TX FIFO drops the write even if the emitter pops in the same cycle.
    assign wr_tx    = bus.reg_wen && (bus.reg_addr == A_TXDATA);
    assign tx_push  = wr_tx && !tx_full;
    assign set_drop = wr_tx && tx_full;
    assign tx_pop   = (state_q == ST_IDLE) && !tx_empty;

    // A same-cycle RXDATA read frees a slot, so a push into a full FIFO still lands.
    assign rd_rx   = bus.reg_ren && (bus.reg_addr == A_RXDATA);
    assign rx_pop  = rd_rx && !rx_empty;
    assign rx_push = bus.rx_valid && (!rx_full || rx_pop);
    assign set_ovr = bus.rx_valid && rx_full && !rx_pop;

    assign clr_ovr  = bus.reg_wen && (bus.reg_addr == A_STATUS) && bus.reg_wdata[4];
    assign clr_drop = bus.reg_wen && (bus.reg_addr == A_STATUS) && bus.reg_wdata[5];

    assign status = {8'h00, 8'(tx_cnt), 8'(rx_cnt), 2'b00,
                     tx_drop_q, rx_ovr_q, rx_empty, rx_full, tx_empty, tx_full};

    assign unused_wdata = &{1'b0, bus.reg_wdata[31:8]};

    always_comb begin
        tx_mem_d  = tx_mem_q;
        rx_mem_d  = rx_mem_q;
        tx_wptr_d = tx_wptr_q + (AW+1)'(tx_push);
        tx_rptr_d = tx_rptr_q + (AW+1)'(tx_pop);
        rx_wptr_d = rx_wptr_q + (AW+1)'(rx_push);
        rx_rptr_d = rx_rptr_q + (AW+1)'(rx_pop);
        if (tx_push) tx_mem_d[tx_wptr_q[AW-1:0]] = bus.reg_wdata[7:0];
        if (rx_push) rx_mem_d[rx_wptr_q[AW-1:0]] = bus.rx_ch;
        tx_drop_d = set_drop || (tx_drop_q && !clr_drop);
        rx_ovr_d  = set_ovr  || (rx_ovr_q  && !clr_ovr);
    end

    // The IDLE cycle that pops the next byte is itself one of the TX_GAP idle
    // cycles, so GAP hands back to IDLE as the count steps down to 1.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        tx_ch_d   = tx_ch_q;
        case (state_q)
            ST_IDLE: begin
                if (tx_pop) begin
                    tx_ch_d = tx_mem_q[tx_rptr_q[AW-1:0]];
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                gap_cnt_d = CW'(TX_GAP);
                state_d   = ST_GAP;
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q - CW'(1);
                if (gap_cnt_q <= CW'(2)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = bus.reg_ren;
        if (bus.reg_ren) begin
            case (bus.reg_addr)
                A_RXDATA: rdata_d = rx_empty ? 32'h0 : {23'b0, 1'b1, rx_mem_q[rx_rptr_q[AW-1:0]]};
                A_STATUS: rdata_d = status;
                default:  rdata_d = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        tx_mem_q <= tx_mem_d;
        rx_mem_q <= rx_mem_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            state_q   <= ST_IDLE;
            gap_cnt_q <= '0;
            tx_ch_q   <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            tx_drop_q <= 1'b0;
            rx_ovr_q  <= 1'b0;
        end else begin
            tx_wptr_q <= tx_wptr_d;
            tx_rptr_q <= tx_rptr_d;
            rx_wptr_q <= rx_wptr_d;
            rx_rptr_q <= rx_rptr_d;
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            tx_ch_q   <= tx_ch_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            tx_drop_q <= tx_drop_d;
            rx_ovr_q  <= rx_ovr_d;
        end
    end

    assign bus.tx_valid   = (state_q == ST_SEND);
    assign bus.tx_ch      = tx_ch_q;
    assign bus.reg_rdata  = rdata_q;
    assign bus.reg_rvalid = rvalid_q;
    assign bus.irq        = !rx_empty;
endmodule

// File: doc/emu_uart_fifo_ctrl.md
EMU_UART_FIFO_CTRL -- requirements
Module: emu_uart_fifo_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning TX and RX FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter TX_GAP, default 4, meaning minimum idle cycles between consecutive tx_valid pulses (>=1).
REQ-003 SHALL have port clk  in  1  sole clock; all logic on posedge.
REQ-004 SHALL have port resetn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port reg_wen  in  1  register write strobe, one write per cycle high.
REQ-006 SHALL have port reg_ren  in  1  register read strobe, one read per cycle high.
REQ-007 SHALL have port reg_addr  in  4  byte address: 0x0 TXDATA, 0x4 RXDATA, 0x8 STATUS; others reserved.
REQ-008 SHALL have port reg_wdata  in  32  write data.
REQ-009 SHALL have port reg_rdata  out  32  read data, registered.
REQ-010 SHALL have port reg_rvalid  out  1  high one cycle when reg_rdata carries a read result.
REQ-011 SHALL have port tx_valid  out  1  single-cycle byte-valid pulse to the downstream UART sink.
REQ-012 SHALL have port tx_ch  out  8  byte qualified by tx_valid.
REQ-013 SHALL have port rx_valid  in  1  single-cycle byte-valid pulse from the UART source.
REQ-014 SHALL have port rx_ch  in  8  byte qualified by rx_valid.
REQ-015 SHALL have port irq  out  1  level, high while RX FIFO non-empty.

Function
REQ-016 SHALL push reg_wdata[7:0] into TX FIFO on reg_wen to 0x0; if TX FIFO full, drop byte and set sticky tx_drop, regardless of same-cycle pop.
REQ-017 SHALL run TX FSM IDLE/SEND/GAP: IDLE with TX FIFO non-empty -> pop head into tx_ch, go SEND; SEND drives tx_valid=1 exactly one cycle, go GAP, counter loaded TX_GAP; GAP decrements, at 1 -> IDLE.
REQ-018 SHALL produce tx_valid in cycle N+2 for a TXDATA write in cycle N with TX FIFO empty and FSM IDLE.
REQ-019 SHALL hold tx_valid low in IDLE and GAP; tx_ch holds last sent byte outside SEND.
REQ-020 SHALL push rx_ch into RX FIFO on rx_valid; if RX FIFO full, discard byte and set sticky rx_overrun.
REQ-021 SHALL on reg_ren to 0x4 return {23'b0, 1'b1, byte} and pop if RX FIFO non-empty, else return 0 with no pop.
REQ-022 SHALL allow same-cycle rx_valid push and RXDATA pop on non-empty FIFO, occupancy unchanged; when full, pop first frees slot so push succeeds.
REQ-023 SHALL return STATUS bits: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] rx_overrun, [5] tx_drop, [15:8] RX occupancy, [23:16] TX occupancy; other bits 0.
REQ-024 SHALL clear rx_overrun/tx_drop on reg_wen to 0x8 with reg_wdata bit[4]/[5] set; set event in same cycle wins over clear.
REQ-025 SHALL return read data one cycle after reg_ren: reg_rdata and reg_rvalid registered; reserved address reads return 0.
REQ-026 SHALL process reg_wen and reg_ren in the same cycle independently; writes to RXDATA and reserved addresses ignored; reads of TXDATA return 0.
REQ-027 SHALL wrap FIFO pointers modulo FIFO_DEPTH using one extra pointer bit to distinguish full from empty.

Reset
REQ-028 SHALL on resetn low immediately force tx_valid=0, tx_ch=0, reg_rdata=0, reg_rvalid=0, irq=0, FSM IDLE, GAP counter 0.
REQ-029 SHALL on reset empty both FIFOs, clear both sticky flags; bytes in flight or queued are discarded, not emitted.
REQ-030 SHALL accept register access and rx_valid from the first clock edge after resetn deasserts.

Verification
REQ-031 SHALL pass: write 0x41,0x42,0x43 to TXDATA back-to-back from IDLE -> tx_valid pulses with 0x41,0x42,0x43, first at N+2, spacing exactly TX_GAP+1 cycles.
REQ-032 SHALL pass: 17 TXDATA writes with FIFO_DEPTH=16 while FSM held (reset-released, first pop consumed) -> excess byte dropped, STATUS[5]=1; write 0x20 to 0x8 -> STATUS[5]=0.
REQ-033 SHALL pass: 17 rx_valid pulses, no reads -> irq=1, STATUS[2]=1, STATUS[4]=1, 16 RXDATA reads return first 16 bytes with bit8=1, 17th read returns 0.
REQ-034 SHALL pass: RX FIFO full, rx_valid 0x55 same cycle as RXDATA read -> read returns oldest byte, 0x55 stored, rx_overrun stays 0.
REQ-035 SHALL pass: resetn low during SEND -> tx_valid drops asynchronously; after release no further tx_valid and STATUS reads 0x0000_000A.
